// File: rtl/mem_arbiter.sv
// Round-robin shared-memory responder: serves up to NCORES cores on one
// synchronous single-port RAM, one access at a time, and returns a one-cycle
// response pulse (plus read data for reads) to the granted core only.
module mem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int NCORES       = 4,
  parameter int ADDR_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NCORES-1:0]        request,
  input  logic [NCORES-1:0]        wren,
  input  logic [NCORES*WIDTH-1:0]  address,
  input  logic [NCORES*WIDTH-1:0]  writedata,
  output logic [NCORES-1:0]        response,
  output logic [WIDTH-1:0]         readdata,
  output logic [ADDR_WIDTH-1:0]    mem_address,
  output logic [WIDTH-1:0]         mem_writedata,
  output logic                     mem_wren,
  output logic                     mem_rden,
  input  logic [WIDTH-1:0]         mem_readdata
);

  localparam int IDX_W = $clog2(NCORES);
  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                 state_reg, state_next;
  logic [IDX_W-1:0]       grant_reg;
  logic [IDX_W-1:0]       last_grant_reg;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       cand;
  logic                   found;
  logic                   capture;
  logic                   wr_reg;
  logic [ADDR_WIDTH-1:0]  addr_reg;
  logic [WIDTH-1:0]       data_reg;
  logic [WIDTH-1:0]       readdata_reg;
  logic [CNT_W-1:0]       cnt_reg;

  logic [ADDR_WIDTH-1:0]  core_addr [NCORES];
  logic [WIDTH-1:0]       core_data [NCORES];

  // Per-core unpacking of the flat buses and the one-hot response decode.
  // Address bits above ADDR_WIDTH never reach the RAM, so addresses wrap.
  generate
    for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
      assign core_addr[gi] = address[gi*WIDTH +: ADDR_WIDTH];
      assign core_data[gi] = writedata[gi*WIDTH +: WIDTH];
      assign response[gi]  = (state_reg == S_RESP) && (grant_reg == IDX_W'(gi));
      if (WIDTH > ADDR_WIDTH) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^address[gi*WIDTH+ADDR_WIDTH +: WIDTH-ADDR_WIDTH];
      end
    end
  endgenerate

  assign readdata      = readdata_reg;
  assign mem_address   = addr_reg;
  assign mem_writedata = data_reg;

  // Round-robin pick: first requester found searching upward from last_grant+1.
  always_comb begin
    winner = last_grant_reg;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NCORES; k++) begin
      cand = IDX_W'((int'(last_grant_reg) + k) % NCORES);
      if (!found && request[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and RAM strobes; strobes are only ever high in ISSUE.
  always_comb begin
    state_next = state_reg;
    mem_wren   = 1'b0;
    mem_rden   = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (found) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        mem_wren   = wr_reg;
        mem_rden   = !wr_reg;
        state_next = wr_reg ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        // Counter reaches 1 in the cycle the RAM presents valid data.
        if (cnt_reg == CNT_W'(1)) begin
          capture    = 1'b1;
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Latch the winner's request; core inputs are looked at only in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_reg      <= '0;
      last_grant_reg <= IDX_W'(NCORES - 1);
      wr_reg         <= 1'b0;
      addr_reg       <= '0;
      data_reg       <= '0;
    end else if (state_reg == S_IDLE && found) begin
      grant_reg      <= winner;
      last_grant_reg <= winner;
      wr_reg         <= wren[winner];
      addr_reg       <= core_addr[winner];
      data_reg       <= core_data[winner];
    end
  end

  // Read-latency counter: loaded in ISSUE, counts down through WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (state_reg == S_ISSUE) begin
      cnt_reg <= CNT_W'(READ_LATENCY);
    end else if (state_reg == S_WAIT) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  // Read-data register; holds its value across writes and idle periods.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readdata_reg <= '0;
    end else if (capture) begin
      readdata_reg <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized core traffic on a
// READ_LATENCY=1 instance checked cycle by cycle against a transaction-level
// model, and a reset-during-read scenario on a READ_LATENCY=3 instance.
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam logic [31:0] JUNK = 32'h5A5A_A5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- READ_LATENCY=1 instance ----------------
  logic            rst_n = 1'b0;
  logic [N-1:0]    request, wren, response;
  logic [N*W-1:0]  address, writedata;
  logic [W-1:0]    readdata, mem_writedata, mem_readdata;
  logic [AW-1:0]   mem_address;
  logic            mem_wren, mem_rden;

  mem_arbiter #(.WIDTH(W), .NCORES(N), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .wren(wren),
    .address(address), .writedata(writedata), .response(response),
    .readdata(readdata), .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_readdata(mem_readdata)
  );

  // ---------------- READ_LATENCY=3 instance ----------------
  logic            rst3_n = 1'b0;
  logic [N-1:0]    request3, wren3, response3;
  logic [N*W-1:0]  address3, writedata3;
  logic [W-1:0]    readdata3, mem_writedata3, mem_readdata3;
  logic [AW-1:0]   mem_address3;
  logic            mem_wren3, mem_rden3;

  mem_arbiter #(.WIDTH(W), .NCORES(N), .ADDR_WIDTH(AW), .READ_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .request(request3), .wren(wren3),
    .address(address3), .writedata(writedata3), .response(response3),
    .readdata(readdata3), .mem_address(mem_address3), .mem_writedata(mem_writedata3),
    .mem_wren(mem_wren3), .mem_rden(mem_rden3), .mem_readdata(mem_readdata3)
  );

  function automatic logic [31:0] init_val(input logic [15:0] a);
    return (a == 16'h0010) ? 32'hDEADBEEF : {a, a ^ 16'hC3C3};
  endfunction

  // ---------------- RAM environments ----------------
  logic        env_clr = 1'b1;
  logic [31:0] ram1 [65536];
  logic [31:0] ram3 [65536];
  logic [31:0] pipe1;
  logic        vld1;
  logic [31:0] dat3 [3];
  logic        vld3 [3];

  // Latency-1 RAM: registered read, write on strobe.
  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 65536; i++) ram1[i] <= init_val(16'(i));
    end else if (mem_wren) begin
      ram1[mem_address] <= mem_writedata;
    end
    vld1  <= mem_rden;
    pipe1 <= ram1[mem_address];
  end
  assign mem_readdata = vld1 ? pipe1 : JUNK;

  // Latency-3 RAM: three-stage read pipeline.
  always @(posedge clk) begin
    if (env_clr) begin
      for (int i = 0; i < 65536; i++) ram3[i] <= init_val(16'(i));
    end else if (mem_wren3) begin
      ram3[mem_address3] <= mem_writedata3;
    end
    vld3[0] <= mem_rden3;
    dat3[0] <= ram3[mem_address3];
    for (int k = 1; k < 3; k++) begin
      vld3[k] <= vld3[k-1];
      dat3[k] <= dat3[k-1];
    end
  end
  assign mem_readdata3 = vld3[2] ? dat3[2] : JUNK;

  // ---------------- reference model state ----------------
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          free_cyc = 0;
  int          iss_cyc  = -1;
  int          rsp_cyc  = -1;
  int          mg       = 0;
  int          m_last   = N - 1;
  bit          m_wr     = 1'b0;
  bit          m_in_reset = 1'b1;
  logic [15:0] m_addr   = '0;
  logic [31:0] m_data   = '0;
  logic [31:0] m_rd_exp = '0;
  logic [31:0] m_hold   = '0;
  logic [31:0] model_mem [65536];
  int          cool [N];
  bit          rnd_on = 1'b0;
  bit          fair   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
      $error("check %s", tag);
    end
  endtask

  // Start of a cycle: sample outputs mid-cycle and compare with the model,
  // then let any core that sees its response drop its request.
  task automatic cyc_begin();
    logic [3:0] exp_resp;
    @(negedge clk);
    cyc++;
    if (iss_cyc >= 0 && cyc == iss_cyc + 1 && m_wr) model_mem[m_addr] = m_data;
    if (cyc == rsp_cyc && !m_wr) m_hold = m_rd_exp;
    exp_resp = (cyc == rsp_cyc) ? 4'(1 << mg) : 4'b0000;
    chk("response", response, exp_resp);
    chk("readdata", readdata, m_hold);
    chk("mem_wren", mem_wren, (cyc == iss_cyc) && m_wr);
    chk("mem_rden", mem_rden, (cyc == iss_cyc) && !m_wr);
    if (cyc == iss_cyc) begin
      chk("mem_address", mem_address, m_addr);
      if (m_wr) chk("mem_writedata", mem_writedata, m_data);
    end
    for (int i = 0; i < N; i++) begin
      if (response[i]) begin
        request[i] = 1'b0;
        cool[i] = fair ? 2 : int'($urandom_range(2, 5));
      end
    end
  endtask

  // End of a cycle: with inputs final, a free arbiter grants round-robin.
  task automatic cyc_end();
    int pick;
    pick = -1;
    if (!m_in_reset && cyc >= free_cyc && request != '0) begin
      for (int k = 1; k <= N; k++) begin
        if (pick < 0 && request[(m_last + k) % N]) pick = (m_last + k) % N;
      end
      mg      = pick;
      m_last  = pick;
      m_wr    = wren[pick];
      m_addr  = address[pick*W +: AW];
      m_data  = writedata[pick*W +: W];
      iss_cyc = cyc + 1;
      if (m_wr) begin
        rsp_cyc  = cyc + 2;
        free_cyc = cyc + 3;
      end else begin
        m_rd_exp = model_mem[m_addr];
        rsp_cyc  = cyc + 3;
        free_cyc = cyc + 4;
      end
    end
  endtask

  task automatic set_core(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
    request[i] = 1'b1;
    wren[i] = w;
    address[i*W +: W] = a;
    writedata[i*W +: W] = d;
  endtask

  task automatic raise(input int i);
    logic [31:0] r;
    r = $urandom;
    set_core(i, r[0], {r[31:16], 16'h0100 + 16'(r[3:1])}, $urandom);
  endtask

  // Random core behaviour; the granted core also scrambles its inputs while
  // the access is in flight, which the arbiter must ignore.
  task automatic rnd_step();
    logic [31:0] r;
    if (!m_in_reset && cyc < free_cyc && request[mg]) begin
      r = $urandom;
      address[mg*W +: W] = r;
      writedata[mg*W +: W] = ~r;
      wren[mg] = ~wren[mg];
    end
    for (int i = 0; i < N; i++) begin
      if (!request[i]) begin
        if (cool[i] > 0) cool[i]--;
        else if (fair || $urandom_range(0, 3) == 0) raise(i);
      end else if (!fair && !(cyc < free_cyc && mg == i) && $urandom_range(0, 49) == 0) begin
        request[i] = 1'b0;
        cool[i] = 2;
      end
    end
  endtask

  // Asserts reset mid-cycle, checks outputs clear at once, releases later;
  // returns in the release (IDLE) cycle before its grant decision.
  task automatic reset1();
    cyc_begin();
    rst_n = 1'b0;
    #1;
    chk("rst_response", response, 0);
    chk("rst_readdata", readdata, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_rden", mem_rden, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_writedata", mem_writedata, 0);
    m_in_reset = 1'b1;
    iss_cyc = -1;
    rsp_cyc = -1;
    m_hold  = '0;
    m_last  = N - 1;
    request = '0;
    for (int i = 0; i < N; i++) cool[i] = 2;
    repeat (2) cyc_begin();
    cyc_begin();
    rst_n = 1'b1;
    m_in_reset = 1'b0;
    free_cyc = cyc;
  endtask

  initial begin
    int t0, r0, r1, prev, idx;
    request = '0; wren = '0; address = '0; writedata = '0;
    request3 = '0; wren3 = '0; address3 = '0; writedata3 = '0;
    for (int i = 0; i < N; i++) cool[i] = 0;
    for (int i = 0; i < 65536; i++) model_mem[i] = init_val(16'(i));
    @(posedge clk);
    #1 env_clr = 1'b0;

    // Single read of 0x0010 by core 0 right after reset.
    reset1();
    t0 = cyc;
    set_core(0, 1'b0, 32'h0000_0010, 32'h0);
    cyc_end();
    for (int k = 1; k <= 4; k++) begin
      cyc_begin();
      if (cyc == t0 + 1) begin
        chk("t1_rden", mem_rden, 1);
        chk("t1_addr", mem_address, 16'h0010);
      end
      if (cyc == t0 + 3) begin
        chk("t1_resp", response, 4'b0001);
        chk("t1_rdata", readdata, 32'hDEADBEEF);
      end
      cyc_end();
    end

    // Core 2 writes 0x00FF, then reads it back through aliased 0x1_00FF.
    cyc_begin();
    t0 = cyc;
    set_core(2, 1'b1, 32'h0000_00FF, 32'h12345678);
    cyc_end();
    for (int k = 1; k <= 3; k++) begin
      cyc_begin();
      if (cyc == t0 + 1) chk("t2_wren", mem_wren, 1);
      if (cyc == t0 + 2) chk("t2_wresp", response, 4'b0100);
      cyc_end();
    end
    cyc_begin();
    t0 = cyc;
    set_core(2, 1'b0, 32'h0001_00FF, 32'h0);
    cyc_end();
    for (int k = 1; k <= 4; k++) begin
      cyc_begin();
      if (cyc == t0 + 1) chk("t2_raddr", mem_address, 16'h00FF);
      if (cyc == t0 + 3) begin
        chk("t2_rresp", response, 4'b0100);
        chk("t2_rdata", readdata, 32'h12345678);
      end
      cyc_end();
    end

    // Contention after reset: cores 0 and 1 read in the same cycle.
    reset1();
    t0 = cyc;
    r0 = -1;
    r1 = -1;
    set_core(0, 1'b0, 32'h0000_0010, 32'h0);
    set_core(1, 1'b0, 32'h0000_00FF, 32'h0);
    cyc_end();
    for (int k = 1; k <= 12; k++) begin
      cyc_begin();
      if (response[0] && r0 < 0) r0 = cyc;
      if (response[1] && r1 < 0) r1 = cyc;
      cyc_end();
    end
    chk("cont_first", r0 - t0, 3);
    chk("cont_gap", r1 - r0, 4);

    // Fairness: every core re-requests as soon as it may.
    fair = 1'b1;
    rnd_on = 1'b1;
    prev = -1;
    for (int i = 0; i < N; i++) cool[i] = 0;
    for (int k = 0; k < 80; k++) begin
      cyc_begin();
      if (response != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (response[i]) idx = i;
        if (prev >= 0) chk("rr_order", idx, (prev + 1) % N);
        prev = idx;
      end
      rnd_step();
      cyc_end();
    end

    // Randomized traffic with withdrawals and one reset in the middle.
    fair = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      if (k == 700) reset1();
      else cyc_begin();
      rnd_step();
      cyc_end();
    end
    rnd_on = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cyc_begin();
      cyc_end();
    end

    // READ_LATENCY=3: reset during WAIT abandons the read; core 3 then wins.
    @(negedge clk);
    rst3_n = 1'b1;
    request3[0] = 1'b1;
    address3[31:0] = 32'h0000_0020;
    @(negedge clk);
    chk("l3_rden", mem_rden3, 1);
    chk("l3_addr", mem_address3, 16'h0020);
    request3[3] = 1'b1;
    address3[3*W +: W] = 32'hABCD_0030;
    @(negedge clk);
    chk("l3_wait_resp", response3, 0);
    rst3_n = 1'b0;
    request3[0] = 1'b0;
    #1;
    chk("l3_rst_response", response3, 0);
    chk("l3_rst_readdata", readdata3, 0);
    chk("l3_rst_mem_wren", mem_wren3, 0);
    chk("l3_rst_mem_rden", mem_rden3, 0);
    chk("l3_rst_mem_address", mem_address3, 0);
    chk("l3_rst_mem_writedata", mem_writedata3, 0);
    repeat (2) begin
      @(negedge clk);
      chk("l3_rst_hold", response3, 0);
    end
    @(negedge clk);
    rst3_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("l3_c3_rden", mem_rden3, 1);
        chk("l3_c3_addr", mem_address3, 16'h0030);
      end
      if (k >= 2 && k <= 4) chk("l3_no_resp", response3, 0);
      if (k == 4) chk("l3_rd_zero", readdata3, 0);
      if (k == 5) begin
        chk("l3_c3_resp", response3, 4'b1000);
        chk("l3_c3_rdata", readdata3, init_val(16'h0030));
        request3[3] = 1'b0;
      end
      if (k == 6) chk("l3_resp_end", response3, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
